// File: rtl/ttl_serial_pkg.sv
// Shared types and constants for the TTL-style serial link.
package ttl_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Clk cycles from the accepting edge until the line is free again.
  function automatic int frame_len(input int clks_per_bit, input int data_bits,
                                   input int stop_bits);
    return (1 + data_bits + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/ttl_serial_baud.sv
// Divide-by-CLKS_PER_BIT bit timer. Counts only while enabled, restarts
// synchronously, and pulses tick on the last cycle of each bit period.
module ttl_serial_baud
  import ttl_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         restart,
  input  logic         en,
  output logic         tick,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  assign tick = en && (count == LAST);

  // Bit-period counter; wraps only on tick, idles at zero when disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          count <= '0;
    else if (restart) count <= '0;
    else if (en)      count <= tick ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/ttl_serial_tx.sv
// Parallel-in, serial-out async transmitter (LSB first, start/stop framing)
// with TTL-style rise/fall propagation delays on its outputs.
module ttl_serial_tx
  import ttl_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int DELAY_RISE   = 0,
  parameter int DELAY_FALL   = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] D,
  input  logic                 Load,
  output logic                 Ready,
  output logic                 Busy,
  output logic                 Tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] PRE_LAST  = BW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("ttl_serial_tx: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_dbits
    $error("ttl_serial_tx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sbits
    $error("ttl_serial_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_e            state;
  logic [DATA_BITS-1:0] sh;
  logic [CW-1:0]        bit_cnt;
  logic                 tx_q, ready_q, busy_q;
  logic                 tick, accept;
  logic [BW-1:0]        baud_cnt;

  // Ready is only high in IDLE or the final stop cycle, so this is the
  // single place a frame can begin.
  assign accept = ready_q & Load;

  ttl_serial_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (Clk),
    .rst     (Reset),
    .restart (accept),
    .en      (busy_q),
    .tick    (tick),
    .count   (baud_cnt)
  );

  // Framing FSM; all outputs registered here.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      sh      <= '0;
      bit_cnt <= '0;
      tx_q    <= IDLE_LEVEL;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Ternary keeps an unknown Load visible on the line.
          tx_q <= accept ? START_LEVEL : IDLE_LEVEL;
          if (accept) begin
            state   <= START;
            sh      <= D;
            bit_cnt <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            tx_q    <= sh[0];
            sh      <= sh >> 1;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_DATA) begin
              state   <= STOP;
              tx_q    <= IDLE_LEVEL;
              bit_cnt <= '0;
            end else begin
              tx_q    <= sh[0];
              sh      <= sh >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          // Open the handshake one cycle early so a waiting Load lands
          // exactly on the stop/start boundary.
          if (bit_cnt == LAST_STOP && baud_cnt == PRE_LAST) ready_q <= 1'b1;
          if (tick) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              if (accept) begin
                state   <= START;
                sh      <= D;
                tx_q    <= START_LEVEL;
                ready_q <= 1'b0;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [2:0] out_q, out_d;
  assign out_q = {tx_q, ready_q, busy_q};

  // Port delays: rising edges follow the DELAY_RISE copy, falling edges the
  // DELAY_FALL copy. Zero delays collapse to plain wires.
  if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_nodly
    assign out_d = out_q;
  end else begin : g_dly
    for (genvar i = 0; i < 3; i++) begin : g_bit
      logic q_r, q_f;
      assign #(DELAY_RISE) q_r = out_q[i];
      assign #(DELAY_FALL) q_f = out_q[i];
      assign out_d[i] = out_q[i] ? q_r : q_f;
    end
  end

  assign {Tx, Ready, Busy} = out_d;

endmodule

// File: tb/tb_ttl_serial_tx.sv
// Self-checking bench for ttl_serial_tx: directed frames plus random bytes
// against a per-cycle frame model, and a delayed instance for edge timing.
module tb_ttl_serial_tx;

  localparam int CPB   = 4;
  localparam int NBITS = 8;
  localparam int FLEN  = (1 + NBITS + 1) * CPB;

  logic       Clk, Reset;
  logic [7:0] D, D2;
  logic       Load, Load2;
  logic       Ready, Busy, Tx;
  logic       Ready2, Busy2, Tx2;

  int compared   = 0;
  int mismatched = 0;

  ttl_serial_tx #(.CLKS_PER_BIT(CPB)) u_dut (
    .Clk(Clk), .Reset(Reset), .D(D), .Load(Load),
    .Ready(Ready), .Busy(Busy), .Tx(Tx)
  );

  ttl_serial_tx #(.CLKS_PER_BIT(CPB), .DELAY_RISE(5), .DELAY_FALL(3)) u_dly (
    .Clk(Clk), .Reset(Reset), .D(D2), .Load(Load2),
    .Ready(Ready2), .Busy(Busy2), .Tx(Tx2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level k cycles after the accepting edge: frame slot k/CPB is start,
  // then data LSB first, then stop.
  function automatic logic model_tx(input logic [7:0] b, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= NBITS) return b[slot-1];
    return 1'b1;
  endfunction

  // Called at a negedge. Presents b with Load, then after the accepting
  // edge puts d_after/load_after on the inputs and checks all FLEN cycles.
  // Returns at the negedge just before the frame's final edge.
  task automatic frame(input string tag, input logic [7:0] b,
                       input logic [7:0] d_after, input logic load_after);
    D = b; Load = 1'b1;
    @(posedge Clk);
    #1 D = d_after; Load = load_after;
    for (int k = 0; k < FLEN; k++) begin
      @(negedge Clk);
      chk({tag, "_tx"}, Tx, model_tx(b, k));
      chk({tag, "_ready"}, Ready, (k == FLEN - 1) ? 8'd1 : 8'd0);
      chk({tag, "_busy"}, Busy, 8'd1);
    end
  endtask

  task automatic idle_chk(input string tag);
    @(negedge Clk);
    chk({tag, "_idle_tx"}, Tx, 8'd1);
    chk({tag, "_idle_ready"}, Ready, 8'd1);
    chk({tag, "_idle_busy"}, Busy, 8'd0);
  endtask

  initial begin
    logic [7:0] b, nb;
    logic       chain;

    Reset = 1'b0; Load = 1'b0; D = '0; Load2 = 1'b0; D2 = '0;
    // Reset with no clock edge yet (first posedge at t=5).
    #1 Reset = 1'b1;
    #2;
    chk("rst0_tx", Tx, 8'd1);
    chk("rst0_ready", Ready, 8'd1);
    chk("rst0_busy", Busy, 8'd0);
    @(negedge Clk) Reset = 1'b0;

    // Single A5 frame, D scrambled after capture.
    frame("a5", 8'hA5, 8'h5A, 1'b0);
    idle_chk("a5");

    // Load held with 3C through an A5 frame: back-to-back, no idle gap.
    frame("a5h", 8'hA5, 8'h3C, 1'b1);
    frame("3c", 8'h3C, 8'h00, 1'b0);
    idle_chk("3c");

    // 00 then FF back to back.
    frame("z", 8'h00, 8'hFF, 1'b1);
    frame("ff", 8'hFF, 8'h00, 1'b0);
    idle_chk("ff");

    // Reset two cycles into data bit 3 of 00 (cycle 18 of the frame).
    D = 8'h00; Load = 1'b1;
    @(posedge Clk);
    #1 Load = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      @(negedge Clk);
      chk("pre_rst_tx", Tx, model_tx(8'h00, k));
    end
    #1 Reset = 1'b1;
    #1;
    chk("midrst_tx", Tx, 8'd1);
    chk("midrst_ready", Ready, 8'd1);
    chk("midrst_busy", Busy, 8'd0);
    @(negedge Clk) Reset = 1'b0;
    frame("x81", 8'h81, 8'h00, 1'b0);
    idle_chk("x81");

    // Random bytes, randomly chained or separated by idle.
    b = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      nb    = 8'($urandom);
      chain = 1'($urandom_range(0, 1));
      frame("rnd", b, nb, chain);
      if (!chain) begin
        idle_chk("rnd");
        @(negedge Clk);
      end
      b = nb;
    end
    // The last loop pass may have left Load high on a chained byte.
    if (Load) begin
      frame("rnd_last", b, 8'h00, 1'b0);
      idle_chk("rnd_last");
    end

    // Delay instance: Tx falls 3 after the accepting edge, Busy rises 5 after.
    @(negedge Clk);
    D2 = 8'h01; Load2 = 1'b1;
    @(posedge Clk);
    #2;
    chk("dly_e0_tx_pre", Tx2, 8'd1);
    chk("dly_e0_ready_pre", Ready2, 8'd1);
    Load2 = 1'b0;
    #2;
    chk("dly_e0_tx_post", Tx2, 8'd0);
    chk("dly_e0_ready_post", Ready2, 8'd0);
    chk("dly_e0_busy_pre", Busy2, 8'd0);
    #2;
    chk("dly_e0_busy_post", Busy2, 8'd1);
    // Start-to-bit-0 edge is the fourth edge after acceptance; bit 0 is 1.
    repeat (4) @(posedge Clk);
    #4;
    chk("dly_b0_tx_pre", Tx2, 8'd0);
    #2;
    chk("dly_b0_tx_post", Tx2, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
